// File: rtl/dbus_bridge_pkg.sv
// Shared core package: data-bus request/response bundles and
// the data-side bus bridge state and constants.
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    COOL
  } dbridge_state_t;

  localparam logic [1:0]  BUS_RESP_OKAY = 2'b00;
  localparam logic [63:0] DBUS_TIMEOUT_DATA = 64'hDEADBEEF_DEADBEEF;

  function automatic logic [63:0] align8(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// Memory-stage request/response port plus split AXI-lite style
// read/write channels toward the memory interconnect.
interface dbus_bridge_if;
  import common::*;

  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [2:0]  ar_size;

  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] aw_addr;
  logic [2:0]  aw_size;

  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;

  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;

  modport master (
    input  dreq,
    output dresp,
    output ar_valid, ar_addr, ar_size,
    input  ar_ready,
    input  r_valid, r_data, r_resp,
    output r_ready,
    output aw_valid, aw_addr, aw_size,
    input  aw_ready,
    output w_valid, w_data, w_strb,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready
  );

  modport slave (
    output dreq,
    input  dresp,
    input  ar_valid, ar_addr, ar_size,
    output ar_ready,
    output r_valid, r_data, r_resp,
    input  r_ready,
    input  aw_valid, aw_addr, aw_size,
    output aw_ready,
    input  w_valid, w_data, w_strb,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready
  );

endinterface

// File: rtl/dbus_bridge.sv
// Data-side bus bridge: one outstanding load/store converted to
// split address/data/response channels, all outputs registered.
module dbus_bridge
  import common::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic          clk,
  input  logic          rst,
  dbus_bridge_if.master bus,
  output logic          bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  dbridge_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;

  logic [63:0] addr_q, addr_n;
  logic [2:0]  size_q, size_n;
  logic [7:0]  strb_q, strb_n;
  logic [63:0] data_q, data_n;

  logic aw_done, aw_done_n;
  logic w_done, w_done_n;

  logic ar_valid_q, ar_valid_n;
  logic r_ready_q, r_ready_n;
  logic aw_valid_q, aw_valid_n;
  logic w_valid_q, w_valid_n;
  logic b_ready_q, b_ready_n;

  dbus_resp_t resp_q, resp_n;
  logic       err_q, err_n;

  logic stall;
  logic aw_hs;
  logic w_hs;

  // Next-state and next-output values for every registered output
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr_q;
    size_n     = size_q;
    strb_n     = strb_q;
    data_n     = data_q;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    ar_valid_n = ar_valid_q;
    r_ready_n  = r_ready_q;
    aw_valid_n = aw_valid_q;
    w_valid_n  = w_valid_q;
    b_ready_n  = b_ready_q;
    resp_n     = resp_q;
    resp_n.addr_ok = 1'b0;
    resp_n.data_ok = 1'b0;
    err_n      = err_q;
    stall      = 1'b0;
    aw_hs      = aw_valid_q && bus.aw_ready;
    w_hs       = w_valid_q && bus.w_ready;

    unique case (state)
      IDLE: begin
        if (bus.dreq.valid) begin
          resp_n.addr_ok = 1'b1;
          addr_n = align8(bus.dreq.addr);
          size_n = bus.dreq.size;
          strb_n = bus.dreq.strobe;
          data_n = bus.dreq.data;
          if (bus.dreq.strobe == 8'h00) begin
            state_n    = RD_ADDR;
            ar_valid_n = 1'b1;
          end else begin
            state_n    = WR_REQ;
            aw_valid_n = 1'b1;
            w_valid_n  = 1'b1;
            aw_done_n  = 1'b0;
            w_done_n   = 1'b0;
          end
        end
      end
      RD_ADDR: begin
        if (bus.ar_ready) begin
          ar_valid_n = 1'b0;
          r_ready_n  = 1'b1;
          state_n    = RD_DATA;
        end else begin
          stall = 1'b1;
        end
      end
      RD_DATA: begin
        if (bus.r_valid) begin
          resp_n.data    = bus.r_data;
          resp_n.data_ok = 1'b1;
          if (bus.r_resp != BUS_RESP_OKAY) err_n = 1'b1;
          r_ready_n = 1'b0;
          state_n   = COOL;
        end else begin
          stall = 1'b1;
        end
      end
      WR_REQ: begin
        aw_done_n  = aw_done || aw_hs;
        w_done_n   = w_done || w_hs;
        aw_valid_n = aw_valid_q && !aw_hs;
        w_valid_n  = w_valid_q && !w_hs;
        if (aw_done_n && w_done_n) begin
          b_ready_n = 1'b1;
          state_n   = WR_RESP;
        end else begin
          stall = 1'b1;
        end
      end
      WR_RESP: begin
        if (bus.b_valid) begin
          resp_n.data_ok = 1'b1;
          if (bus.b_resp != BUS_RESP_OKAY) err_n = 1'b1;
          b_ready_n = 1'b0;
          state_n   = COOL;
        end else begin
          stall = 1'b1;
        end
      end
      COOL: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (stall && cnt == CNT_MAX) begin
      err_n          = 1'b1;
      resp_n.data_ok = 1'b1;
      resp_n.data    = DBUS_TIMEOUT_DATA;
      ar_valid_n     = 1'b0;
      r_ready_n      = 1'b0;
      aw_valid_n     = 1'b0;
      w_valid_n      = 1'b0;
      b_ready_n      = 1'b0;
      state_n        = COOL;
    end

    if (state_n != state) begin
      cnt_n = '0;
    end else if (stall) begin
      cnt_n = cnt + 1'b1;
    end
  end

  // State, latched request, channel controls and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      strb_q     <= '0;
      data_q     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      resp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      addr_q     <= addr_n;
      size_q     <= size_n;
      strb_q     <= strb_n;
      data_q     <= data_n;
      aw_done    <= aw_done_n;
      w_done     <= w_done_n;
      ar_valid_q <= ar_valid_n;
      r_ready_q  <= r_ready_n;
      aw_valid_q <= aw_valid_n;
      w_valid_q  <= w_valid_n;
      b_ready_q  <= b_ready_n;
      resp_q     <= resp_n;
      err_q      <= err_n;
    end
  end

  assign bus.dresp    = resp_q;
  assign bus.ar_valid = ar_valid_q;
  assign bus.ar_addr  = addr_q;
  assign bus.ar_size  = size_q;
  assign bus.r_ready  = r_ready_q;
  assign bus.aw_valid = aw_valid_q;
  assign bus.aw_addr  = addr_q;
  assign bus.aw_size  = size_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = data_q;
  assign bus.w_strb   = strb_q;
  assign bus.b_ready  = b_ready_q;
  assign bus_err_o    = err_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Testbench for dbus_bridge: directed scenarios plus randomized
// loads/stores against a word-memory reference model.
module tb_dbus_bridge;
  import common::*;

  logic clk = 1'b0;
  logic rst;
  logic bus_err_o;

  always #5 clk = ~clk;

  dbus_bridge_if bus();

  dbus_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .bus_err_o(bus_err_o)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] o_rdata, o_aaddr, o_waddr, o_wdata;
  logic [2:0]  o_asize, o_wsize;
  logic [7:0]  o_wstrb;
  int o_lat, o_nar, o_naw, o_nw, o_nok, o_naok, o_narv;

  logic [63:0] bus_mem [8];
  logic [63:0] model_mem [8];

  function automatic logic [63:0] merge(input logic [63:0] old,
                                        input logic [63:0] nw,
                                        input logic [7:0] st);
    logic [63:0] m;
    m = old;
    for (int b = 0; b < 8; b++)
      if (st[b]) m[b*8 +: 8] = nw[b*8 +: 8];
    return m;
  endfunction

  task automatic idle_inputs();
    bus.ar_ready = 1'b0;
    bus.r_valid  = 1'b0;
    bus.r_data   = '0;
    bus.r_resp   = 2'b00;
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.b_resp   = 2'b00;
  endtask

  // Acts as requester and memory slave for one request; waits are
  // counted from the first cycle the bridge raises the matching signal.
  task automatic run_txn(input logic [63:0] a, input logic [2:0] sz,
                         input logic [7:0] st, input logic [63:0] d,
                         input int ar_w, input int r_w, input int aw_w,
                         input int w_w, input int b_w,
                         input logic [1:0] rsp, input logic [63:0] rd,
                         input bit hold);
    int ar_age, r_age, aw_age, w_age, b_age, c;
    bit done;
    ar_age = 0; r_age = 0; aw_age = 0; w_age = 0; b_age = 0;
    o_rdata = '0; o_aaddr = '0; o_waddr = '0; o_wdata = '0;
    o_asize = '0; o_wsize = '0; o_wstrb = '0;
    o_lat = -1; o_nar = 0; o_naw = 0; o_nw = 0;
    o_nok = 0; o_naok = 0; o_narv = 0;
    idle_inputs();
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = a;
    bus.dreq.size   = sz;
    bus.dreq.strobe = st;
    bus.dreq.data   = d;
    c = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      if (bus.ar_valid && bus.ar_ready) begin
        o_nar++; o_aaddr = bus.ar_addr; o_asize = bus.ar_size;
      end
      if (bus.aw_valid && bus.aw_ready) begin
        o_naw++; o_waddr = bus.aw_addr; o_wsize = bus.aw_size;
      end
      if (bus.w_valid && bus.w_ready) begin
        o_nw++; o_wdata = bus.w_data; o_wstrb = bus.w_strb;
      end
      @(posedge clk); #1;
      c++;
      if (!hold) bus.dreq.valid = 1'b0;
      if (bus.ar_valid) o_narv++;
      if (bus.dresp.addr_ok) o_naok++;
      if (bus.dresp.data_ok) begin
        o_nok++; o_rdata = bus.dresp.data; o_lat = c; done = 1'b1;
      end
      bus.ar_ready = bus.ar_valid && (ar_age >= ar_w);
      if (bus.ar_valid) ar_age++;
      bus.r_valid = bus.r_ready && (r_age >= r_w);
      if (bus.r_ready) r_age++;
      bus.r_data = rd;
      bus.r_resp = rsp;
      bus.aw_ready = bus.aw_valid && (aw_age >= aw_w);
      if (bus.aw_valid) aw_age++;
      bus.w_ready = bus.w_valid && (w_age >= w_w);
      if (bus.w_valid) w_age++;
      bus.b_valid = bus.b_ready && (b_age >= b_w);
      if (bus.b_ready) b_age++;
      bus.b_resp = rsp;
    end
    idle_inputs();
    @(posedge clk); #1;
    bus.dreq.valid = 1'b0;
    if (bus.dresp.data_ok) o_nok++;
    if (bus.dresp.addr_ok) o_naok++;
    if (bus.ar_valid) o_narv++;
  endtask

  task automatic test_reset();
    logic [6:0] v;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v = {bus.ar_valid, bus.r_ready, bus.aw_valid, bus.w_valid,
         bus.b_ready, bus.dresp.addr_ok, bus.dresp.data_ok};
    checks++;
    if (v !== 7'b0) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0000000", v);
    end
    checks++;
    if (bus.dresp.data !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", bus.dresp.data);
    end
    checks++;
    if (bus_err_o !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", bus_err_o);
    end
    checks++;
    if ({bus.ar_addr, bus.aw_addr, bus.w_data} !== 192'h0) begin
      failures++; $display("FAIL reset_bus got=%h/%h/%h exp=0",
                           bus.ar_addr, bus.aw_addr, bus.w_data);
    end
    checks++;
    if ({bus.w_strb, bus.ar_size, bus.aw_size} !== 14'h0) begin
      failures++; $display("FAIL reset_strb got=%h exp=0", bus.w_strb);
    end
    rst = 1'b1;
  endtask

  task automatic test_load_zero_wait();
    run_txn(64'h80000013, 3'd2, 8'h00, 64'h0, 0, 0, 0, 0, 0, 2'b00,
            64'h1122334455667788, 1'b0);
    checks++;
    if (o_aaddr !== 64'h80000010) begin
      failures++; $display("FAIL load_araddr got=%h exp=80000010", o_aaddr);
    end
    checks++;
    if (o_asize !== 3'd2) begin
      failures++; $display("FAIL load_arsize got=%0d exp=2", o_asize);
    end
    checks++;
    if (o_lat !== 3) begin
      failures++; $display("FAIL load_latency got=%0d exp=3", o_lat);
    end
    checks++;
    if (o_rdata !== 64'h1122334455667788) begin
      failures++; $display("FAIL load_data got=%h exp=1122334455667788", o_rdata);
    end
    checks++;
    if (o_nar !== 1 || o_naok !== 1 || o_nok !== 1) begin
      failures++; $display("FAIL load_counts got=ar%0d aok%0d ok%0d exp=1/1/1",
                           o_nar, o_naok, o_nok);
    end
  endtask

  task automatic test_store_w_first();
    run_txn(64'h8000010C, 3'd3, 8'hF0, 64'hAABBCCDD_00000000,
            0, 0, 2, 0, 2, 2'b00, 64'h0, 1'b0);
    checks++;
    if (o_naw !== 1 || o_nw !== 1) begin
      failures++; $display("FAIL store_xfers got=aw%0d w%0d exp=1/1", o_naw, o_nw);
    end
    checks++;
    if (o_waddr !== 64'h80000108 || o_wsize !== 3'd3) begin
      failures++; $display("FAIL store_aw got=%h/%0d exp=80000108/3", o_waddr, o_wsize);
    end
    checks++;
    if (o_wstrb !== 8'hF0 || o_wdata !== 64'hAABBCCDD_00000000) begin
      failures++; $display("FAIL store_w got=%h/%h exp=f0/aabbccdd00000000",
                           o_wstrb, o_wdata);
    end
    checks++;
    if (o_nok !== 1 || o_lat !== 7) begin
      failures++; $display("FAIL store_dataok got=n%0d lat%0d exp=n1 lat7", o_nok, o_lat);
    end
    checks++;
    if (bus_err_o !== 1'b0) begin
      failures++; $display("FAIL store_err got=%b exp=0", bus_err_o);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    run_txn(64'h80000040, 3'd3, 8'h00, 64'h0, 0, 0, 0, 0, 0, 2'b00,
            64'h5555AAAA5555AAAA, 1'b1);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.ar_valid || bus.dresp.addr_ok) extra++;
    end
    checks++;
    if (o_naok !== 1 || o_nar !== 1 || o_narv !== 1) begin
      failures++; $display("FAIL b2b_accept got=aok%0d ar%0d arv%0d exp=1/1/1",
                           o_naok, o_nar, o_narv);
    end
    checks++;
    if (extra !== 0) begin
      failures++; $display("FAIL b2b_idle got=%0d exp=0", extra);
    end
    checks++;
    if (o_rdata !== 64'h5555AAAA5555AAAA || o_lat !== 3) begin
      failures++; $display("FAIL b2b_data got=%h lat%0d exp=5555aaaa5555aaaa lat3",
                           o_rdata, o_lat);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  idx, sz;
      logic [7:0]  st;
      logic [63:0] a, ea, d, rd, ex;
      int w0, w1, w2, el;
      idx = 3'($urandom_range(0, 7));
      a = 64'h80000000 | {58'd0, idx, 3'($urandom_range(0, 7))};
      ea = a & ~64'h7;
      sz = 3'($urandom_range(0, 3));
      st = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      d = {$urandom, $urandom};
      w0 = $urandom_range(0, 3);
      w1 = $urandom_range(0, 3);
      w2 = $urandom_range(0, 3);
      if (st == 8'h00) begin
        rd = bus_mem[idx];
        ex = model_mem[idx];
        el = 3 + w0 + w1;
        run_txn(a, sz, st, d, w0, w1, 0, 0, 0, 2'b00, rd, 1'b0);
        checks++;
        if (o_rdata !== ex || o_lat !== el) begin
          failures++; $display("FAIL rnd_load%0d got=%h lat%0d exp=%h lat%0d",
                               i, o_rdata, o_lat, ex, el);
        end
        checks++;
        if (o_aaddr !== ea || o_asize !== sz || o_nar !== 1) begin
          failures++; $display("FAIL rnd_ar%0d got=%h/%0d n%0d exp=%h/%0d n1",
                               i, o_aaddr, o_asize, o_nar, ea, sz);
        end
      end else begin
        el = 3 + ((w0 > w1) ? w0 : w1) + w2;
        run_txn(a, sz, st, d, 0, 0, w0, w1, w2, 2'b00, 64'h0, 1'b0);
        checks++;
        if (o_waddr !== ea || o_wsize !== sz || o_naw !== 1) begin
          failures++; $display("FAIL rnd_aw%0d got=%h/%0d n%0d exp=%h/%0d n1",
                               i, o_waddr, o_wsize, o_naw, ea, sz);
        end
        checks++;
        if (o_wdata !== d || o_wstrb !== st || o_nw !== 1) begin
          failures++; $display("FAIL rnd_w%0d got=%h/%h n%0d exp=%h/%h n1",
                               i, o_wdata, o_wstrb, o_nw, d, st);
        end
        checks++;
        if (o_lat !== el) begin
          failures++; $display("FAIL rnd_slat%0d got=%0d exp=%0d", i, o_lat, el);
        end
        bus_mem[o_waddr[5:3]] = merge(bus_mem[o_waddr[5:3]], o_wdata, o_wstrb);
        model_mem[idx] = merge(model_mem[idx], d, st);
      end
      checks++;
      if (o_nok !== 1 || o_naok !== 1) begin
        failures++; $display("FAIL rnd_pulses%0d got=ok%0d aok%0d exp=1/1",
                             i, o_nok, o_naok);
      end
    end
  endtask

  task automatic test_error_resp();
    run_txn(64'h80000200, 3'd3, 8'h00, 64'h0, 0, 1, 0, 0, 0, 2'b10,
            64'hCAFEF00D12345678, 1'b0);
    checks++;
    if (o_rdata !== 64'hCAFEF00D12345678 || o_nok !== 1) begin
      failures++; $display("FAIL err_data got=%h n%0d exp=cafef00d12345678 n1",
                           o_rdata, o_nok);
    end
    checks++;
    if (bus_err_o !== 1'b1) begin
      failures++; $display("FAIL err_set got=%b exp=1", bus_err_o);
    end
    run_txn(64'h80000208, 3'd3, 8'h00, 64'h0, 0, 0, 0, 0, 0, 2'b00,
            64'h0F0F0F0F0F0F0F0F, 1'b0);
    run_txn(64'h80000210, 3'd3, 8'h01, 64'h77, 0, 0, 0, 0, 0, 2'b00,
            64'h0, 1'b0);
    checks++;
    if (bus_err_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", bus_err_o);
    end
  endtask

  task automatic test_reset_mid_write();
    int stray;
    idle_inputs();
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = 64'h80000020;
    bus.dreq.size   = 3'd3;
    bus.dreq.strobe = 8'hFF;
    bus.dreq.data   = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    bus.dreq.valid = 1'b0;
    bus.aw_ready = 1'b1;
    bus.w_ready  = 1'b1;
    @(posedge clk); #1;
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    checks++;
    if (bus.b_ready !== 1'b1) begin
      failures++; $display("FAIL rmw_bready got=%b exp=1", bus.b_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.b_ready, bus.aw_valid, bus.w_valid, bus.dresp.data_ok,
         bus.dresp.addr_ok, bus_err_o} !== 6'b0) begin
      failures++; $display("FAIL rmw_ctl got=%b%b%b%b%b%b exp=000000",
                           bus.b_ready, bus.aw_valid, bus.w_valid,
                           bus.dresp.data_ok, bus.dresp.addr_ok, bus_err_o);
    end
    checks++;
    if ({bus.aw_addr, bus.w_data, bus.dresp.data} !== 192'h0 ||
        bus.w_strb !== 8'h00) begin
      failures++; $display("FAIL rmw_payload got=%h/%h/%h/%h exp=0",
                           bus.aw_addr, bus.w_data, bus.dresp.data, bus.w_strb);
    end
    rst = 1'b1;
    bus.b_valid = 1'b1;
    stray = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.dresp.data_ok) stray++;
    end
    bus.b_valid = 1'b0;
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL rmw_no_dataok got=%0d exp=0", stray);
    end
    run_txn(64'h80000028, 3'd3, 8'h00, 64'h0, 0, 0, 0, 0, 0, 2'b00,
            64'h00000000DEADC0DE, 1'b0);
    checks++;
    if (o_lat !== 3 || o_rdata !== 64'h00000000DEADC0DE) begin
      failures++; $display("FAIL rmw_idle_load got=lat%0d %h exp=lat3 00000000deadc0de",
                           o_lat, o_rdata);
    end
  endtask

  task automatic test_timeout();
    checks++;
    if (bus_err_o !== 1'b0) begin
      failures++; $display("FAIL to_pre_err got=%b exp=0", bus_err_o);
    end
    run_txn(64'h80000300, 3'd3, 8'h00, 64'h0, 1000, 0, 0, 0, 0, 2'b00,
            64'h0, 1'b0);
    checks++;
    if (o_narv !== 8 || o_nar !== 0) begin
      failures++; $display("FAIL to_arvalid got=cyc%0d xfer%0d exp=cyc8 xfer0",
                           o_narv, o_nar);
    end
    checks++;
    if (o_rdata !== 64'hDEADBEEFDEADBEEF || o_nok !== 1 || o_lat !== 9) begin
      failures++; $display("FAIL to_dataok got=%h n%0d lat%0d exp=deadbeefdeadbeef n1 lat9",
                           o_rdata, o_nok, o_lat);
    end
    checks++;
    if (bus_err_o !== 1'b1) begin
      failures++; $display("FAIL to_err got=%b exp=1", bus_err_o);
    end
  endtask

  initial begin
    logic [63:0] v;
    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom};
      bus_mem[i] = v;
      model_mem[i] = v;
    end
    bus.dreq = '0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_load_zero_wait();
    test_store_w_first();
    test_back_to_back();
    test_random();
    test_error_resp();
    test_reset_mid_write();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-side bus bridge between the memory-access stage's `dbus_req_t`/`dbus_resp_t` port and the external memory interconnect. It accepts one load or store at a time from the memory-access stage. It converts the request into AXI-lite-style split address, data and response channels, and returns a single `data_ok` pulse carrying the raw 64-bit beat. Byte/half/word extraction and sign extension stay in the memory-access stage; this block moves whole aligned 64-bit words plus strobes.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1023: bus-stall cycles tolerated in any wait state before the error flag is set. Counter width is `$clog2(TIMEOUT_CYC+1)`.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `dreq` in `dbus_req_t`: `valid`, `addr`[63:0], `size`[2:0], `strobe`[7:0], `data`[63:0]. `strobe==0` means a load; any nonzero value means a store.
- `dresp` out `dbus_resp_t`: `addr_ok`, `data_ok`, `data`[63:0].
- `ar_valid` out 1, `ar_ready` in 1, `ar_addr` out 64, `ar_size` out 3: read address channel.
- `r_valid` in 1, `r_ready` out 1, `r_data` in 64, `r_resp` in 2: read data channel.
- `aw_valid` out 1, `aw_ready` in 1, `aw_addr` out 64, `aw_size` out 3: write address channel.
- `w_valid` out 1, `w_ready` in 1, `w_data` out 64, `w_strb` out 8: write data channel.
- `b_valid` in 1, `b_ready` out 1, `b_resp` in 2: write response channel.
- `bus_err_o` out 1: sticky error flag. Set by a nonzero `r_resp`/`b_resp` or by a timeout. Cleared only by reset.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, COOL.
- **IDLE:** on `dreq.valid`, pulse `addr_ok` for one cycle and latch `addr`, `size`, `strobe` and `data` into internal registers. Go to RD_ADDR if `strobe==0`, otherwise WR_REQ.
- **Address alignment:** outgoing addresses are `{addr[63:3],3'b0}`. Outgoing `*_size` equals the latched `size`.
- **RD_ADDR:** `ar_valid=1` until `ar_valid&&ar_ready`, then go to RD_DATA.
- **RD_DATA:** `r_ready=1`. On `r_valid`:
  - `dresp.data<=r_data` and pulse `data_ok` for one cycle.
  - If `r_resp!=0`, set `bus_err_o`.
  - Go to COOL.
- **WR_REQ:** `aw_valid` and `w_valid` are asserted together and tracked by independent done bits `aw_done`/`w_done`. Each valid drops the cycle after its own handshake. When both are done, go to WR_RESP.
  - Either handshake may come first, or both in the same cycle.
  - `w_data`/`w_strb` are the latched store data and strobe, passed through unshifted.
- **WR_RESP:** `b_ready=1`. On `b_valid`:
  - Pulse `data_ok`; `dresp.data` is left unchanged.
  - If `b_resp!=0`, set `bus_err_o`.
  - Go to COOL.
- **COOL:** exactly one cycle with `dreq.valid` ignored. This covers the requester dropping `valid` one edge after `data_ok`. Then go to IDLE.
- **Timeout:** a per-state stall counter resets on every state change. If it reaches `TIMEOUT_CYC` in RD_ADDR, RD_DATA, WR_REQ or WR_RESP:
  - set `bus_err_o`;
  - pulse `data_ok` with `dresp.data=64'hDEADBEEF_DEADBEEF`;
  - drop all bus valids;
  - go to COOL.
- **Latched fields:** request fields are latched only in IDLE. Changes on `dreq` while busy have no effect.

## Timing
- **Reset values:** all valids/readies 0, `addr_ok`/`data_ok` 0, `dresp.data` 0, `bus_err_o` 0, addresses/data/strb 0, state IDLE. Reset mid-transaction abandons it with no `data_ok`.
- **Outputs:** all bus-side and `dresp` outputs are registered; there is no combinational path from `dreq` to the bus.
- **Minimum load latency:** 3 cycles from `valid` sampled in IDLE to `data_ok`, with zero-wait `ar_ready`/`r_valid`:
  - edge 1 → RD_ADDR;
  - edge 2 → RD_DATA;
  - edge 3 → `data_ok` high.
- **Minimum store latency:** 3 cycles on the same basis, with `aw`/`w` accepted together.
- **Issue rate:** back-to-back requests are accepted at most every 4 cycles (3 + COOL).
- **Response pulses:** `addr_ok` and `data_ok` are each high for exactly one cycle per request.
- **Bus handshake stability:** once a bus valid is raised, it and its payload stay stable until the ready handshake or a timeout.

## Structure
- Add to the shared `common` package:
  - enum `dbridge_state_t` for the six states;
  - `localparam` `BUS_RESP_OKAY=2'b00`;
  - `localparam` `DBUS_TIMEOUT_DATA` for the timeout data value.
- `dbus_req_t`/`dbus_resp_t` are reused unchanged from the package.
- No sub-module: a single FSM with a latch register and a stall counter.

## Test plan
- **Load, zero-wait:** `addr=0x80000013`, `size=2`, `strobe=0`.
  - `ar_addr=0x80000010`, `ar_size=2`.
  - Return `r_data=0x1122334455667788`: `data_ok` arrives exactly 3 cycles after IDLE sampled `valid`, with that data.
- **Store, W before AW:** `strobe=8'hF0`, `data=0xAABBCCDD_00000000`.
  - `w_ready` in cycle 1, `aw_ready` in cycle 3, `b_valid` 2 cycles later.
  - One AW and one W transfer; `w_strb=8'hF0`; a single `data_ok`.
- **Back-to-back:** `valid` held high through `data_ok`+1 → COOL swallows it; no second AR issues until the requester re-presents a request.
- **Error response:** `r_resp=2'b10` → `data_ok` with `r_data`; `bus_err_o` goes to 1 and stays 1 through later OKAY transfers.
- **Timeout:** `TIMEOUT_CYC=8`, `ar_ready` held 0 → after 8 cycles `ar_valid` drops, `data_ok` pulses with `0xDEADBEEFDEADBEEF`, and `bus_err_o=1`.
- **Reset mid-write:** `rst=0` in WR_RESP → next cycle all outputs are at reset values, the FSM is in IDLE, and no `data_ok` is emitted.
